// File: rtl/cpu_mem_responder_pkg.sv
// Shared decode constants and read-source encoding for the CPU memory responder.
// Imported by the responder top and its sub-modules.
package cpu_mem_responder_pkg;

    localparam logic [1:0]  IO_SEL       = 2'b11;
    localparam logic [31:0] IO_UART_ADDR = 32'h0003_0000;
    localparam logic [31:0] IO_END_ADDR  = 32'h0003_0004;

    typedef enum logic [1:0] {
        RD_RAM    = 2'd0,
        RD_RX     = 2'd1,
        RD_STATUS = 2'd2,
        RD_ZERO   = 2'd3
    } rd_sel_e;

endpackage

// File: rtl/cpu_mem_responder_tx_fifo.sv
// Parameterised byte FIFO (push/pop/count/full) used for UART transmit buffering.
// A pop frees a slot in the same edge, so push+pop is accepted even when full.
module responder_tx_fifo #(
    parameter int DEPTH   = 8,
    parameter int DEPTH_W = 3
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               i_push,
    input  logic [7:0]         i_data,
    input  logic               i_pop,
    output logic [7:0]         o_data,
    output logic [DEPTH_W:0]   o_count,
    output logic               o_full
);

    localparam logic [DEPTH_W:0] L_FULL = (DEPTH_W + 1)'(DEPTH);

    logic [7:0]         r_buf [DEPTH];
    logic [DEPTH_W-1:0] r_head;
    logic [DEPTH_W-1:0] r_tail;
    logic [DEPTH_W:0]   r_count;
    logic               w_pop;
    logic               w_push;

    assign w_pop   = i_pop & (r_count != '0);
    assign w_push  = i_push & ((r_count != L_FULL) | w_pop);
    assign o_data  = r_buf[r_head];
    assign o_count = r_count;
    assign o_full  = (r_count == L_FULL);

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_buf[r_tail] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// CPU byte-bus responder: RAM / IO decode, 1-cycle read return, UART TX FIFO,
// single-byte UART RX holding register and sticky program-end latch.
module cpu_mem_responder
    import cpu_mem_responder_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH      = 17,
    parameter int TX_FIFO_DEPTH       = 8,
    parameter int TX_FIFO_DEPTH_WIDTH = 3
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic [31:0]               mem_a,
    input  logic                      mem_wr,
    input  logic [7:0]                mem_dout,
    output logic [7:0]                mem_din,
    output logic                      io_buffer_full,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]                ram_wdata,
    input  logic [7:0]                ram_rdata,
    output logic                      tx_valid,
    output logic [7:0]                tx_data,
    input  logic                      tx_ready,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    output logic                      rx_ready,
    output logic                      program_end,
    output logic                      tx_overflow
);

    localparam logic [TX_FIFO_DEPTH_WIDTH:0] L_WARN =
        (TX_FIFO_DEPTH_WIDTH + 1)'(TX_FIFO_DEPTH - 2);

    logic                           w_io;
    logic                           w_is_uart;
    logic                           w_is_end;
    logic                           w_rx_rd;
    logic                           w_rx_fill;
    logic                           w_tx_wr;
    logic                           w_tx_pop;
    logic                           w_fifo_full;
    logic [TX_FIFO_DEPTH_WIDTH:0]   w_count;
    rd_sel_e                        w_rd_sel_nxt;
    rd_sel_e                        r_rd_sel;
    logic                           r_rd_live;
    logic                           r_rx_full;
    logic [7:0]                     r_rx_data;
    logic [7:0]                     r_rx_out;
    logic                           r_program_end;
    logic                           r_tx_overflow;

    assign w_io      = (mem_a[17:16] == IO_SEL);
    assign w_is_uart = (mem_a == IO_UART_ADDR);
    assign w_is_end  = (mem_a == IO_END_ADDR);

    assign ram_en    = rdy_in & ~w_io;
    assign ram_we    = ram_en & mem_wr;
    assign ram_addr  = mem_a[RAM_ADDR_WIDTH-1:0];
    assign ram_wdata = mem_dout;

    // Handshakes (tx and rx): a byte moves on a clock edge only when valid and
    // ready are both high; valid never waits on ready, ready never on valid.
    assign w_rx_rd   = rdy_in & ~mem_wr & w_is_uart;
    assign w_rx_fill = rx_valid & rx_ready;
    assign rx_ready  = ~r_rx_full & ~rst_in;
    assign w_tx_wr   = rdy_in & mem_wr & w_is_uart;
    assign w_tx_pop  = tx_valid & tx_ready;

    assign tx_valid       = (w_count != '0);
    assign io_buffer_full = (w_count >= L_WARN);
    assign program_end    = r_program_end;
    assign tx_overflow    = r_tx_overflow;

    responder_tx_fifo #(
        .DEPTH   (TX_FIFO_DEPTH),
        .DEPTH_W (TX_FIFO_DEPTH_WIDTH)
    ) u_tx_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_push  (w_tx_wr),
        .i_data  (mem_dout),
        .i_pop   (w_tx_pop),
        .o_data  (tx_data),
        .o_count (w_count),
        .o_full  (w_fifo_full)
    );

    always_comb begin
        w_rd_sel_nxt = RD_RAM;
        if (w_io) begin
            if (w_is_uart)     w_rd_sel_nxt = RD_RX;
            else if (w_is_end) w_rd_sel_nxt = RD_STATUS;
            else               w_rd_sel_nxt = RD_ZERO;
        end
    end

    // r_rd_live keeps mem_din at zero until the first bus cycle after reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_rd_sel  <= RD_RAM;
            r_rd_live <= 1'b0;
        end else if (rdy_in) begin
            r_rd_sel  <= w_rd_sel_nxt;
            r_rd_live <= 1'b1;
        end
    end

    always_comb begin
        mem_din = '0;
        if (r_rd_live) begin
            case (r_rd_sel)
                RD_RAM:    mem_din = ram_rdata;
                RD_RX:     mem_din = r_rx_out;
                RD_STATUS: mem_din = {7'b0, tx_valid};
                default:   mem_din = '0;
            endcase
        end
    end

    // A read of an empty register returns 0 even if a byte lands the same edge.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_rx_full <= 1'b0;
            r_rx_data <= '0;
            r_rx_out  <= '0;
        end else begin
            if (w_rx_rd) r_rx_out <= r_rx_full ? r_rx_data : 8'h00;
            if (w_rx_fill) begin
                r_rx_full <= 1'b1;
                r_rx_data <= rx_data;
            end else if (w_rx_rd && r_rx_full) begin
                r_rx_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_program_end <= 1'b0;
            r_tx_overflow <= 1'b0;
        end else begin
            if (rdy_in && mem_wr && w_is_end)          r_program_end <= 1'b1;
            if (w_tx_wr && w_fifo_full && !w_tx_pop)   r_tx_overflow <= 1'b1;
        end
    end

endmodule
